// File: rtl/fpga_cnn_pkg.sv
// rtl/fpga_cnn_pkg.sv - shared float32 field positions, types and stack FSM states
package fpga_cnn_pkg;

   localparam int FP32_SIGN_BIT = 31;
   localparam int FP32_EXP_MSB  = 30;
   localparam int FP32_EXP_LSB  = 23;
   localparam logic [7:0] FP32_EXP_ALL_ONES = 8'hFF;

   typedef logic [31:0] fp32_t;

   typedef enum logic {
      ST_IDLE     = 1'b0,
      ST_READ_OUT = 1'b1
   } stack_state_t;

endpackage

// File: rtl/relu_sign_mask.sv
// rtl/relu_sign_mask.sv - combinational strictly-positive, finite test per float32 element
module relu_sign_mask
   import fpga_cnn_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  fp32_t            i_vec [WIDTH],
   output logic [WIDTH-1:0] o_mask
);

   // Zero, negatives, Inf and NaN all map to 0; denormals count as positive.
   always_comb begin
      o_mask = '0;
      for (int j = 0; j < WIDTH; j++) begin
         o_mask[j] = !i_vec[j][FP32_SIGN_BIT]
                   && (i_vec[j][FP32_EXP_MSB:FP32_EXP_LSB] != FP32_EXP_ALL_ONES)
                   && (i_vec[j][FP32_EXP_MSB:0] != '0);
      end
   end

endmodule

// File: rtl/relu_mask_stack.sv
// rtl/relu_mask_stack.sv - LIFO of per-element ReLU masks replayed in reverse for backprop
module relu_mask_stack
   import fpga_cnn_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 64
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       fwd_push,
   input  fp32_t                      fwd_vec [WIDTH],
   input  logic                       bwd_pop,
   output logic [WIDTH-1:0]           mask_out,
   output logic                       mask_valid,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty,
   output logic                       overflow,
   output logic                       underflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [CW-1:0]    r_count;
   logic             r_full;
   logic             r_empty;
   logic             r_overflow;
   logic             r_underflow;
   logic [WIDTH-1:0] r_mask_out;
   stack_state_t     r_state;

   logic [WIDTH-1:0] w_mask;
   logic             w_pop_ok;
   logic             w_push_ok;
   logic [AW-1:0]    w_top_idx;
   logic [AW-1:0]    w_wr_idx;
   logic [CW-1:0]    w_count_nxt;
   stack_state_t     w_state_nxt;

   relu_sign_mask #(.WIDTH(WIDTH)) u_sign_mask (
      .i_vec  (fwd_vec),
      .o_mask (w_mask)
   );

   // A pop frees the top slot, so a push is still accepted when full.
   assign w_pop_ok  = bwd_pop && !r_empty;
   assign w_push_ok = fwd_push && (!r_full || bwd_pop);
   assign w_top_idx = r_count[AW-1:0] - AW'(1);
   assign w_wr_idx  = w_pop_ok ? w_top_idx : r_count[AW-1:0];

   always_comb begin
      w_count_nxt = r_count;
      if (w_push_ok && !w_pop_ok) begin
         w_count_nxt = r_count + CW'(1);
      end else if (w_pop_ok && !w_push_ok) begin
         w_count_nxt = r_count - CW'(1);
      end
   end

   always_comb begin
      w_state_nxt = ST_IDLE;
      if (w_pop_ok) begin
         w_state_nxt = ST_READ_OUT;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push_ok) begin
         r_mem[w_wr_idx] <= w_mask;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_count     <= '0;
         r_full      <= 1'b0;
         r_empty     <= 1'b1;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
         r_mask_out  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_count <= w_count_nxt;
         r_full  <= (w_count_nxt == CW'(DEPTH));
         r_empty <= (w_count_nxt == '0);
         if (fwd_push && r_full && !bwd_pop) begin
            r_overflow <= 1'b1;
         end
         if (bwd_pop && r_empty && !fwd_push) begin
            r_underflow <= 1'b1;
         end
         if (w_pop_ok) begin
            r_mask_out <= r_mem[w_top_idx];
         end
      end
   end

   assign mask_out   = r_mask_out;
   assign mask_valid = (r_state == ST_READ_OUT);
   assign count      = r_count;
   assign full       = r_full;
   assign empty      = r_empty;
   assign overflow   = r_overflow;
   assign underflow  = r_underflow;

endmodule

// File: doc/relu_mask_stack.md
Name: relu_mask_stack

Overview:
- LIFO store of per-element ReLU forward masks, sitting directly upstream of relu_backward_layer.
- During the forward pass it captures, for each WIDTH-element activation vector, which elements were strictly positive.
- During the backward pass it replays those masks in reverse order. relu_backward_layer uses them to select pass-through or NEGATIVE_SLOPE scaling of each gradient element.
- Stores 1 bit per element, not the 32-bit activations.

Parameters:
- WIDTH, 8, number of 32-bit IEEE-754 single elements per vector; must match relu_backward_layer WIDTH.
- DEPTH, 64, maximum number of stored mask vectors; power of two, at least 2.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- fwd_push  input  1  capture mask of fwd_vec this cycle.
- fwd_vec  input  32 x [WIDTH-1:0] unpacked  forward ReLU input vector, float32 per element.
- bwd_pop  input  1  request the most recently stored mask.
- mask_out  output  WIDTH  popped mask; bit j = 1 means element j was > 0.
- mask_valid  output  1  one-cycle pulse: mask_out updated this cycle.
- count  output  $clog2(DEPTH)+1  number of stored masks.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- overflow  output  1  sticky; a push was dropped because the stack was full.
- underflow  output  1  sticky; a pop was ignored because the stack was empty.

Behaviour:
- Reset values: mask_out = 0, mask_valid = 0, count = 0, full = 0, empty = 1, overflow = 0, underflow = 0.
- Reset applied mid-operation discards all stored entries. Storage contents need not be cleared.
- Mask rule for element j: bit = 1 iff sign = 0, exponent != 8'hFF, and bits[30:0] != 0.
  - Consequences: +0.0 → 0; -0.0 → 0; negatives → 0; any NaN → 0; +Inf → 0, because the exponent-all-ones test also excludes +Inf; positive denormals → 1.
- Push, when fwd_push = 1 and not full:
  - mask written at index count; count increments.
  - Mask is computed combinationally from fwd_vec in the same cycle.
- Pop, when bwd_pop = 1 and not empty:
  - entry at index count-1 is read.
  - mask_out is registered and appears on the next rising edge, together with mask_valid = 1 for exactly one cycle.
  - count decrements. Latency is 1 cycle.
- mask_out holds its last value until the next accepted pop.
- Simultaneous push and pop, not empty:
  - pop returns the current top (pre-push value).
  - the pushed mask overwrites that same slot.
  - count unchanged; mask_valid pulses next cycle.
- Simultaneous push and pop, empty: push accepted, count becomes 1; pop ignored; underflow NOT set.
- Simultaneous push and pop, full: behaves as the not-empty case; no overflow.
- Push when full and no pop: push dropped, overflow set; stored data and count unchanged.
- Pop when empty and no push: ignored, underflow set; mask_valid stays 0.
- overflow and underflow clear only on reset.
- full and empty are registered, consistent with count in the same cycle. They are not combinational functions of the inputs.
- Control flow is a 2-state FSM: IDLE and READ_OUT.
  - READ_OUT is entered on an accepted pop and drives the mask_valid pulse.
  - It returns to IDLE next cycle unless another pop is accepted, in which case it stays in READ_OUT and mask_valid remains high.
  - Back-to-back pops are therefore supported at 1 mask per cycle.

Decomposition:
- fpga_cnn_pkg holds:
  - FP32_SIGN_BIT = 31
  - FP32_EXP_MSB = 30, FP32_EXP_LSB = 23
  - FP32_EXP_ALL_ONES = 8'hFF
  - typedef logic [31:0] fp32_t
- One sub-module: relu_sign_mask. Purely combinational; fp32_t [WIDTH] in, WIDTH-bit mask out; instantiated once on fwd_vec.
- Storage is an inferred DEPTH x WIDTH register/RAM array inside relu_mask_stack.

Test Plan:
- Reset, then push fwd_vec = {3F800000, BF800000, 00000000, 80000000, 7F800000, 7FC00000, 00000001, C0000000} (element 0 first) → next pop gives mask_out = 8'b0100_0001 (bit0 = 1.0, bit6 = denormal); mask_valid high exactly 1 cycle after pop.
- Push 3 vectors with masks A = 8'hFF, B = 8'h0F, C = 8'hA5 → three back-to-back pops give C, B, A on consecutive cycles; mask_valid high 3 cycles; empty = 1 after, count = 0.
- Push DEPTH vectors → full = 1, count = DEPTH; one more push → overflow = 1, count unchanged; pop returns the DEPTH-th mask, not the dropped one.
- Pop on empty → underflow = 1, mask_valid stays 0, mask_out keeps its previous value; simultaneous push+pop on empty → count = 1, underflow unchanged.
- With top = 8'h3C, simultaneous push of mask 8'hC3 and pop → mask_out = 8'h3C next cycle, count unchanged; a following pop returns 8'hC3.
- Push 5 entries, assert reset for 1 cycle → count = 0, empty = 1, overflow = underflow = 0, mask_out = 0; subsequent pop sets underflow.
